// File: rtl/mult_dispatch.sv
// Convolution operand dispatcher: loads a kernel, then fans each image pixel out into
// one multiplier operand pair per kernel tap, tagged with its full-convolution coordinate.
module mult_dispatch #(
    parameter int K_DIM  = 3,
    parameter int I_DIM  = 8,
    parameter int M_BITS = 16,
    parameter int K_SIZE = K_DIM * K_DIM,
    parameter int T_BITS = $clog2(K_SIZE + 1),
    parameter int I_BITS = $clog2(I_DIM + 1),
    parameter int O_DIM  = K_DIM + I_DIM - 1,
    parameter int O_BITS = $clog2(O_DIM + 1)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [M_BITS-1:0]            k_data,
    input  logic                         k_last,
    input  logic                         k_valid,
    output logic                         k_ready,
    input  logic [M_BITS-1:0]            in_data,
    input  logic [1:0][I_BITS-1:0]       in_user,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [M_BITS-1:0]            mul_a,
    output logic [M_BITS-1:0]            mul_b,
    output logic [1:0][O_BITS-1:0]       mul_user,
    output logic                         mul_last,
    output logic                         mul_valid,
    input  logic                         mul_ready
);

    typedef enum logic [1:0] {LOAD, IDLE, ISSUE} state_t;

    localparam logic [T_BITS-1:0] LAST_TAP = T_BITS'(K_SIZE - 1);
    localparam logic [T_BITS-1:0] LAST_COL = T_BITS'(K_DIM - 1);

    state_t state;
    state_t state_next;

    logic [M_BITS-1:0] kernel [K_SIZE];
    logic [T_BITS-1:0] load_idx;
    logic [T_BITS-1:0] tap;
    logic [T_BITS-1:0] tap_row;
    logic [T_BITS-1:0] tap_col;
    logic [M_BITS-1:0] pix;
    logic [I_BITS-1:0] row;
    logic [I_BITS-1:0] col;
    logic              last_q;

    logic k_fire;
    logic in_fire;
    logic mul_fire;
    logic tap_end;
    logic load_end;

    assign k_fire   = k_valid && k_ready;
    assign in_fire  = in_valid && in_ready;
    assign mul_fire = mul_valid && mul_ready;
    assign tap_end  = (tap == LAST_TAP);
    assign load_end = k_fire && (k_last || (load_idx == LAST_TAP));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (load_end) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mul_ready && tap_end) begin
                    if (last_q) begin
                        state_next = LOAD;
                    end else if (in_valid) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // in_ready in ISSUE lets the next pixel slip in on the final tap with no bubble
    always_comb begin
        k_ready   = 1'b0;
        in_ready  = 1'b0;
        mul_valid = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        mul_user  = '0;
        mul_last  = 1'b0;
        case (state)
            LOAD: begin
                k_ready = 1'b1;
            end
            IDLE: begin
                in_ready = 1'b1;
            end
            ISSUE: begin
                mul_valid   = 1'b1;
                in_ready    = tap_end && mul_ready && !last_q;
                mul_a       = pix;
                mul_b       = kernel[tap];
                mul_user[1] = O_BITS'(row) + O_BITS'(tap_row);
                mul_user[0] = O_BITS'(col) + O_BITS'(tap_col);
                mul_last    = last_q && tap_end;
            end
            default: begin
                k_ready = 1'b0;
            end
        endcase
    end

    // An early k_last zeroes the taps above it so no stale weights survive a reload
    always_ff @(posedge clk) begin
        if (!rstn) begin
            load_idx <= '0;
            for (int i = 0; i < K_SIZE; i++) begin
                kernel[i] <= '0;
            end
        end else if (k_fire) begin
            load_idx <= load_end ? '0 : load_idx + T_BITS'(1);
            for (int i = 0; i < K_SIZE; i++) begin
                if (T_BITS'(i) == load_idx) begin
                    kernel[i] <= k_data;
                end else if (load_end && (T_BITS'(i) > load_idx)) begin
                    kernel[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pix     <= '0;
            row     <= '0;
            col     <= '0;
            last_q  <= 1'b0;
            tap     <= '0;
            tap_row <= '0;
            tap_col <= '0;
        end else if (in_fire) begin
            pix     <= in_data;
            row     <= in_user[1];
            col     <= in_user[0];
            last_q  <= in_last;
            tap     <= '0;
            tap_row <= '0;
            tap_col <= '0;
        end else if (mul_fire && !tap_end) begin
            tap <= tap + T_BITS'(1);
            if (tap_col == LAST_COL) begin
                tap_col <= '0;
                tap_row <= tap_row + T_BITS'(1);
            end else begin
                tap_col <= tap_col + T_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch: kernel loads, per-pixel tap fan-out, a streamed
// frame, back-pressure and mid-issue reset, all checked against hand-derived values.
module tb_mult_dispatch;

    logic             clk = 1'b0;
    logic             rstn;
    logic [15:0]      k_data;
    logic             k_last;
    logic             k_valid;
    logic             k_ready;
    logic [15:0]      in_data;
    logic [1:0][3:0]  in_user;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      mul_a;
    logic [15:0]      mul_b;
    logic [1:0][3:0]  mul_user;
    logic             mul_last;
    logic             mul_valid;
    logic             mul_ready;

    int assertCount = 0;
    int failCount   = 0;
    logic [15:0] kexp [9];

    mult_dispatch dut (
        .clk       (clk),
        .rstn      (rstn),
        .k_data    (k_data),
        .k_last    (k_last),
        .k_valid   (k_valid),
        .k_ready   (k_ready),
        .in_data   (in_data),
        .in_user   (in_user),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_user  (mul_user),
        .mul_last  (mul_last),
        .mul_valid (mul_valid),
        .mul_ready (mul_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1; loads n words first, first+1, ... with k_last on the n-th
    task automatic loadKernel(input int n, input logic [15:0] first);
        int guard;
        for (int i = 0; i < 9; i++) begin
            kexp[i] = (i < n) ? first + 16'(i) : 16'h0;
        end
        for (int i = 0; i < n; i++) begin
            k_valid = 1'b1;
            k_data  = first + 16'(i);
            k_last  = (i == n - 1);
            #1;
            guard = 0;
            while (!k_ready && guard < 20) begin
                @(posedge clk); #2;
                guard++;
            end
            checkOutput("k_ready_load", k_ready, 1);
            @(posedge clk); #1;
        end
        k_valid = 1'b0;
        k_last  = 1'b0;
    endtask

    // Sends one pixel and checks every issued beat; stops after 'beats' handshakes
    task automatic applyStimulus(input logic [15:0] pix, input int r, input int c,
                                 input bit last, input bit toggle, input int beats);
        int t;
        int guard;
        bit rdy;
        in_data  = pix;
        in_user  = {4'(r), 4'(c)};
        in_last  = last;
        in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        checkOutput("in_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        t = 0;
        guard = 0;
        rdy = 1'b1;
        while (t < beats && guard < 60) begin
            mul_ready = toggle ? rdy : 1'b1;
            rdy = !rdy;
            #1;
            checkOutput("mul_valid", mul_valid, 1);
            checkOutput("mul_a", mul_a, pix);
            checkOutput("mul_b", mul_b, kexp[t]);
            checkOutput("mul_user", mul_user, {4'(r + t / 3), 4'(c + t % 3)});
            checkOutput("mul_last", mul_last, last && t == 8);
            checkOutput("in_ready_issue", in_ready, t == 8 && mul_ready && !last);
            if (mul_valid && mul_ready) begin
                t++;
            end
            @(posedge clk); #1;
            guard++;
        end
        mul_ready = 1'b1;
        checkOutput("beat_count", t, beats);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pixIdx;
        int beat;
        int gaps;
        int guard;
        int p;
        int t;
        bit firstSeen;

        rstn      = 1'b0;
        k_data    = '0;
        k_last    = 1'b0;
        k_valid   = 1'b0;
        in_data   = '0;
        in_user   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        mul_ready = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_k_ready", k_ready, 1);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_mul_valid", mul_valid, 0);
        checkOutput("rst_mul_last", mul_last, 0);
        checkOutput("rst_mul_a", mul_a, 0);
        checkOutput("rst_mul_b", mul_b, 0);
        checkOutput("rst_mul_user", mul_user, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] kernel 1..9, pixel 0x3C00 at (0,0)");
        loadKernel(9, 16'd1);
        k_valid = 1'b1;
        #1;
        checkOutput("surplus_k_ready", k_ready, 0);
        checkOutput("idle_in_ready", in_ready, 1);
        k_valid = 1'b0;
        applyStimulus(16'h3C00, 0, 0, 1'b0, 1'b0, 9);

        $display("[TB] idle with in_valid low");
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("idle_mul_valid", mul_valid, 0);
            checkOutput("idle_in_ready2", in_ready, 1);
            @(posedge clk); #1;
        end

        $display("[TB] back-pressure on pixel (3,4)");
        applyStimulus(16'h4200, 3, 4, 1'b0, 1'b1, 9);
        applyStimulus(16'h4400, 5, 2, 1'b1, 1'b0, 9);
        #1;
        checkOutput("reload_k_ready", k_ready, 1);
        checkOutput("reload_mul_valid", mul_valid, 0);
        @(posedge clk); #1;

        $display("[TB] early k_last kernel, pixel at (7,7)");
        loadKernel(4, 16'd5);
        applyStimulus(16'hBC00, 7, 7, 1'b1, 1'b0, 9);

        $display("[TB] full 8x8 frame");
        loadKernel(9, 16'd1);
        pixIdx = 0; beat = 0; gaps = 0; guard = 0; firstSeen = 1'b0;
        while (beat < 576 && guard < 2000) begin
            if (pixIdx < 64) begin
                in_valid = 1'b1;
                in_data  = 16'h2000 + 16'(pixIdx);
                in_user  = {4'(pixIdx / 8), 4'(pixIdx % 8)};
                in_last  = (pixIdx == 63);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            if (mul_valid) begin
                p = beat / 9;
                t = beat % 9;
                checkOutput("f_mul_a", mul_a, 16'h2000 + 16'(p));
                checkOutput("f_mul_b", mul_b, kexp[t]);
                checkOutput("f_mul_user", mul_user, {4'(p / 8 + t / 3), 4'(p % 8 + t % 3)});
                checkOutput("f_mul_last", mul_last, beat == 575);
                beat++;
                firstSeen = 1'b1;
            end else if (firstSeen) begin
                gaps++;
            end
            if (in_valid && in_ready) begin
                pixIdx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("frame_beats", beat, 576);
        checkOutput("frame_gaps", gaps, 0);
        checkOutput("frame_pixels", pixIdx, 64);
        #1;
        checkOutput("frame_k_ready", k_ready, 1);
        checkOutput("frame_mul_valid", mul_valid, 0);
        @(posedge clk); #1;

        $display("[TB] reset at tap 4");
        loadKernel(9, 16'd1);
        applyStimulus(16'h3800, 1, 1, 1'b0, 1'b0, 4);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        checkOutput("mid_rst_mul_valid", mul_valid, 0);
        checkOutput("mid_rst_k_ready", k_ready, 1);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        loadKernel(1, 16'h00AA);
        applyStimulus(16'h3A00, 0, 0, 1'b1, 1'b0, 9);
        loadKernel(9, 16'd1);
        applyStimulus(16'h3B00, 2, 6, 1'b1, 1'b0, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
